porta_sfr: RTL and testbench

PORTA_SFR -- requirements
Module: porta_sfr

---
 rtl/porta_pkg.sv | 24 ++
 rtl/porta_sync.sv | 24 ++
 rtl/porta_sfr.sv | 94 +++++++++
 tb/tb_porta_sfr.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/porta_pkg.sv
// Shared constants and address decode for the port A special-function registers.
package porta_pkg;

  localparam int              PORTA_W    = 5;
  localparam logic [7:0]      ADDR_PORTA = 8'h05;
  localparam logic [7:0]      ADDR_TRISA = 8'h85;
  localparam logic [PORTA_W-1:0] TRISA_RST = 5'h1F;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_PORTA = 2'd1,
    SEL_TRISA = 2'd2
  } reg_sel_e;

  // Map an SFR address onto the register it selects; anything else is unmapped.
  function automatic reg_sel_e decode_addr(input logic [7:0] a);
    reg_sel_e s;
    s = SEL_NONE;
    if (a == ADDR_PORTA) s = SEL_PORTA;
    else if (a == ADDR_TRISA) s = SEL_TRISA;
    return s;
  endfunction

endpackage

// File: rtl/porta_sync.sv
// Two-flop synchronizer for asynchronous pin levels.
module porta_sync #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First stage may go metastable; second stage gives a clean level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/porta_sfr.sv
// Port A SFR block: PORTA output latch, TRISA direction register, pin read-back
// through a synchronizer, and RA4 edge detection for the timer clock input.
module porta_sfr
  import porta_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTA_W-1:0] pin_in,
  input  logic [7:0]         addr,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic [PORTA_W-1:0] pin_out,
  output logic [PORTA_W-1:0] pin_oe,
  output logic               t0cki_rise,
  output logic               t0cki_fall
);

  reg_sel_e           sel;
  logic               wr_porta;
  logic               wr_trisa;
  logic [PORTA_W-1:0] sync;
  logic [PORTA_W-1:0] latch;
  logic [PORTA_W-1:0] trisa;
  logic [PORTA_W-1:0] latch_nxt;
  logic [PORTA_W-1:0] trisa_nxt;
  logic               prev_ra4;
  logic [1:0]         arm_cnt;
  logic               armed;
  logic               unused_wr_hi;

  // Only the low five bits of a write land anywhere.
  assign unused_wr_hi = ^wr_data[7:5];

  porta_sync #(.W(PORTA_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin_in),
    .q   (sync)
  );

  assign sel       = decode_addr(addr);
  assign wr_porta  = wr_en && (sel == SEL_PORTA);
  assign wr_trisa  = wr_en && (sel == SEL_TRISA);
  assign latch_nxt = wr_porta ? wr_data[PORTA_W-1:0] : latch;
  assign trisa_nxt = wr_trisa ? wr_data[PORTA_W-1:0] : trisa;

  // Register state and pin drive; drive is derived from next-state so the pins
  // follow on the same edge as the write. RA4 is open-drain: it can only pull low.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch   <= '0;
      trisa   <= TRISA_RST;
      pin_out <= '0;
      pin_oe  <= '0;
    end else begin
      latch   <= latch_nxt;
      trisa   <= trisa_nxt;
      pin_out <= {1'b0, latch_nxt[3:0]};
      pin_oe  <= {~trisa_nxt[4] & ~latch_nxt[4], ~trisa_nxt[3:0]};
    end
  end

  // Read port samples pre-write values; holds when no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      case (sel)
        SEL_PORTA: rd_data <= {3'b000, sync};
        SEL_TRISA: rd_data <= {3'b000, trisa};
        default:   rd_data <= 8'h00;
      endcase
    end
  end

  // Track previous RA4 and hold off edge detection until the synchronizer
  // pipeline has been refilled after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ra4 <= 1'b0;
      arm_cnt  <= 2'd0;
    end else begin
      prev_ra4 <= sync[4];
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign armed      = (arm_cnt == 2'd3) && !rst;
  assign t0cki_rise = armed &  sync[4] & ~prev_ra4;
  assign t0cki_fall = armed & ~sync[4] &  prev_ra4;

endmodule

// File: tb/tb_porta_sfr.sv
// Scoreboard bench for porta_sfr: stimulus pushes timed expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_porta_sfr;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] pin_in;
  logic [7:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [4:0] pin_out;
  logic [4:0] pin_oe;
  logic       t0cki_rise;
  logic       t0cki_fall;

  localparam int S_RD   = 0;
  localparam int S_POUT = 1;
  localparam int S_POE  = 2;
  localparam int S_RISE = 3;
  localparam int S_FALL = 4;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  porta_sfr dut (
    .clk        (clk),
    .rst        (rst),
    .pin_in     (pin_in),
    .addr       (addr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .pin_out    (pin_out),
    .pin_oe     (pin_oe),
    .t0cki_rise (t0cki_rise),
    .t0cki_fall (t0cki_fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sample(input int s);
    case (s)
      S_RD:    return rd_data;
      S_POUT:  return {3'b000, pin_out};
      S_POE:   return {3'b000, pin_oe};
      S_RISE:  return {7'b0, t0cki_rise};
      default: return {7'b0, t0cki_fall};
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        logic [7:0] act;
        act = sample(q[i].sel);
        n_check++;
        if (q[i].due < cyc || act !== q[i].exp) begin
          n_fail++;
          $display("FAIL %s cycle %0d: got 0x%02h expected 0x%02h", q[i].name, cyc, act, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  // Advance to just after the next rising edge; inputs set afterwards are
  // sampled on the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int d, input int s, input logic [7:0] e, input string nm);
    chk_t c;
    c.due  = cyc + d;
    c.sel  = s;
    c.exp  = e;
    c.name = nm;
    q.push_back(c);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; addr = 8'h00; wr_data = 8'h00;
  endtask

  initial begin
    rst = 1'b1; pin_in = 5'h00;
    idle();
    tick(); tick();
    n_check++;
    if (pin_oe !== 5'h00) begin n_fail++; $display("FAIL direct rst pin_oe: got 0x%02h", pin_oe); end
    n_check++;
    if (pin_out !== 5'h00) begin n_fail++; $display("FAIL direct rst pin_out: got 0x%02h", pin_out); end
    n_check++;
    if (t0cki_rise !== 1'b0) begin n_fail++; $display("FAIL direct rst t0cki_rise: got %b", t0cki_rise); end
    n_check++;
    if (t0cki_fall !== 1'b0) begin n_fail++; $display("FAIL direct rst t0cki_fall: got %b", t0cki_fall); end
    n_check++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL direct rst rd_data: got 0x%02h", rd_data); end
    expect_at(0, S_POE,  8'h00, "rst_pin_oe");
    expect_at(0, S_POUT, 8'h00, "rst_pin_out");
    expect_at(0, S_RISE, 8'h00, "rst_rise");
    expect_at(0, S_FALL, 8'h00, "rst_fall");
    expect_at(0, S_RD,   8'h00, "rst_rd");
    rst = 1'b0; rd_en = 1'b1; addr = 8'h85;
    expect_at(1, S_RD, 8'h1F, "rst_trisa_rd");
    tick();
    addr = 8'h05;
    expect_at(1, S_RD, 8'h00, "rst_porta_rd");
    tick(); idle();

    // Direction then data: RA4 input, RA3..RA0 outputs
    wr_en = 1'b1; addr = 8'h85; wr_data = 8'h10;
    expect_at(1, S_POE, 8'h0F, "trisa10_oe");
    tick();
    n_check++;
    if (pin_oe !== 5'h0F) begin n_fail++; $display("FAIL direct trisa10 pin_oe: got 0x%02h", pin_oe); end
    addr = 8'h05; wr_data = 8'h0A;
    expect_at(1, S_POE,  8'h0F, "porta0a_oe");
    expect_at(1, S_POUT, 8'h0A, "porta0a_out");
    tick();
    n_check++;
    if (pin_out !== 5'h0A) begin n_fail++; $display("FAIL direct porta0a pin_out: got 0x%02h", pin_out); end

    // RA4 open-drain behaviour
    addr = 8'h85; wr_data = 8'h00;
    expect_at(1, S_POE, 8'h1F, "trisa00_oe");
    tick();
    addr = 8'h05; wr_data = 8'h10;
    expect_at(1, S_POE,  8'h0F, "ra4_hi_oe");
    expect_at(1, S_POUT, 8'h00, "ra4_hi_out");
    tick();
    wr_data = 8'h00;
    expect_at(1, S_POE,  8'h1F, "ra4_lo_oe");
    expect_at(1, S_POUT, 8'h00, "ra4_lo_out");
    tick(); idle();

    // Pin read latency and rising edge timing
    pin_in = 5'h15; rd_en = 1'b1; addr = 8'h05;
    expect_at(1, S_RD,   8'h00, "lat_rd_n1");
    expect_at(2, S_RD,   8'h00, "lat_rd_n2");
    expect_at(3, S_RD,   8'h15, "lat_rd_n3");
    expect_at(1, S_RISE, 8'h00, "rise_n1");
    expect_at(2, S_RISE, 8'h01, "rise_n2");
    expect_at(3, S_RISE, 8'h00, "rise_n3");
    expect_at(2, S_FALL, 8'h00, "nofall_n2");
    repeat (4) tick();
    // Falling edge with reads stopped: rd_data must hold
    pin_in = 5'h00; rd_en = 1'b0;
    expect_at(1, S_FALL, 8'h00, "fall_n1");
    expect_at(2, S_FALL, 8'h01, "fall_n2");
    expect_at(3, S_FALL, 8'h00, "fall_n3");
    expect_at(4, S_RD,   8'h15, "rd_hold");
    repeat (4) tick();

    // RA4 rising just before reset, held high through it
    pin_in = 5'h10;
    tick();
    rst = 1'b1;
    tick(); tick();
    expect_at(0, S_RISE, 8'h00, "rst2_rise");
    expect_at(0, S_POE,  8'h00, "rst2_oe");
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) expect_at(k, S_RISE, 8'h00, "post_rst_norise");
    repeat (6) tick();
    pin_in = 5'h00;
    expect_at(1, S_FALL, 8'h00, "rst_fall_n1");
    expect_at(2, S_FALL, 8'h01, "rst_fall_n2");
    expect_at(3, S_FALL, 8'h00, "rst_fall_n3");
    repeat (4) tick();

    // Same-cycle read and write of TRISA returns the old value
    wr_en = 1'b1; rd_en = 1'b1; addr = 8'h85; wr_data = 8'h03;
    expect_at(1, S_RD, 8'h1F, "rdwr_old");
    tick();
    wr_en = 1'b0;
    expect_at(1, S_RD, 8'h03, "rdwr_new");
    tick();
    rd_en = 1'b0; wr_en = 1'b1; addr = 8'h07; wr_data = 8'hFF;
    expect_at(1, S_POE,  8'h1C, "unmapped_oe");
    expect_at(1, S_POUT, 8'h00, "unmapped_out");
    tick();
    wr_en = 1'b0; rd_en = 1'b1; addr = 8'h85;
    expect_at(1, S_RD, 8'h03, "unmapped_trisa");
    tick();
    addr = 8'h07;
    expect_at(1, S_RD, 8'h00, "unmapped_rd");
    tick();
    rd_en = 1'b0; wr_en = 1'b1; addr = 8'h05; wr_data = 8'hFF;
    expect_at(1, S_POUT, 8'h0F, "portaff_out");
    expect_at(1, S_POE,  8'h0C, "portaff_oe");
    tick(); idle();

    repeat (3) tick();
    while (q.size() > 0) begin
      n_check++;
      n_fail++;
      $display("FAIL %s: never compared, due cycle %0d", q[0].name, q[0].due);
      q.delete(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
